// File: rtl/load_store_unit_if.sv
// CPU-side request/response handshake plus the data-memory bus of the load/store unit.
// slave is the unit's view; master is the pipeline/memory environment's view.
interface load_store_unit_if #(parameter int WORD_SIZE = 32);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [2:0]           req_funct3;
    logic [WORD_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [WORD_SIZE-1:0] resp_rdata;
    logic                 resp_error;
    logic                 mem_write_en;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_write_data;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_error, mem_write_en, mem_addr, mem_write_data
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_error, mem_write_en, mem_addr, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding RISC-V load/store unit in front of a word-write, byte-addressed memory.
// Sub-word stores are done as read-modify-write of the 4 bytes at the request address.
module load_store_unit #(
    parameter int WORD_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    logic [2:0]           state;
    logic                 lat_write;
    logic [2:0]           lat_funct3;
    logic [WORD_SIZE-1:0] lat_addr;
    logic [WORD_SIZE-1:0] lat_wdata;
    logic [WORD_SIZE-1:0] wr_data;
    logic [WORD_SIZE-1:0] rdata_q;
    logic                 error_q;
    logic [WORD_SIZE-1:0] load_ext;
    logic [WORD_SIZE-1:0] merged;
    logic                 req_err;

    function automatic logic bad_req(input logic w, input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000:  bad_req = 1'b0;
            3'b001:  bad_req = a[0];
            3'b010:  bad_req = (a != 2'b00);
            3'b100:  bad_req = w;
            3'b101:  bad_req = w | a[0];
            default: bad_req = 1'b1;
        endcase
    endfunction

    assign req_err = bad_req(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);

    always_comb begin
        load_ext = bus.mem_rdata;
        case (lat_funct3)
            3'b000:  load_ext = {{(WORD_SIZE-8){bus.mem_rdata[7]}},   bus.mem_rdata[7:0]};
            3'b001:  load_ext = {{(WORD_SIZE-16){bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
            3'b100:  load_ext = {{(WORD_SIZE-8){1'b0}},  bus.mem_rdata[7:0]};
            3'b101:  load_ext = {{(WORD_SIZE-16){1'b0}}, bus.mem_rdata[15:0]};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    // funct3[0] separates SH from SB; anything else never reaches READ
    assign merged = lat_funct3[0] ? {bus.mem_rdata[WORD_SIZE-1:16], lat_wdata[15:0]}
                                  : {bus.mem_rdata[WORD_SIZE-1:8],  lat_wdata[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lat_write  <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            wr_data    <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    lat_write  <= bus.req_write;
                    lat_funct3 <= bus.req_funct3;
                    lat_addr   <= bus.req_addr;
                    lat_wdata  <= bus.req_wdata;
                    rdata_q    <= '0;
                    error_q    <= req_err;
                    if (req_err)                      state <= RESP;
                    else if (!bus.req_write)          state <= LOAD;
                    else if (bus.req_funct3 == 3'b010) begin
                        wr_data <= bus.req_wdata;
                        state   <= WRITE;
                    end else                          state <= READ;
                end
                LOAD: begin
                    rdata_q <= load_ext;
                    state   <= RESP;
                end
                READ: begin
                    wr_data <= merged;
                    state   <= WRITE;
                end
                WRITE: state <= RESP;
                RESP:  if (bus.resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // write enable decodes straight from state so reset kills it without waiting for an edge
    assign bus.mem_write_en   = (state == WRITE) && lat_write;
    assign bus.mem_addr       = lat_addr;
    assign bus.mem_write_data = wr_data;
    assign bus.req_ready      = (state == IDLE);
    assign bus.resp_valid     = (state == RESP);
    assign bus.resp_rdata     = rdata_q;
    assign bus.resp_error     = error_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: byte-array memory model behind the unit, immediate-assertion checks.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    load_store_unit_if #(.WORD_SIZE(32)) bus ();
    load_store_unit #(.WORD_SIZE(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // 256-byte little-endian memory; addresses wrap, mirroring truncation in the real memory
    logic [7:0] mem [256];
    always_comb begin
        for (int i = 0; i < 4; i++)
            bus.mem_rdata[8*i +: 8] = mem[8'(bus.mem_addr + 32'(i))];
    end
    always @(posedge clk) begin
        if (bus.mem_write_en)
            for (int i = 0; i < 4; i++)
                mem[8'(bus.mem_addr + 32'(i))] <= bus.mem_write_data[8*i +: 8];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request with resp_ready=1; report latency, response and any write seen.
    task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic er,
                       output int wen_cnt, output logic [31:0] wdat, output logic [31:0] waddr);
        wen_cnt = 0; wdat = '0; waddr = '0;
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 16) begin
            if (bus.mem_write_en) begin
                wen_cnt++; wdat = bus.mem_write_data; waddr = bus.mem_addr;
            end
            @(posedge clk); #1;
            lat++;
        end
        rd = bus.resp_rdata; er = bus.resp_error;
        if (bus.mem_write_en) wen_cnt++;
        @(posedge clk); #1;
    endtask

    int          lat, wen;
    logic [31:0] rd, wdat, waddr, held;
    logic        er;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;

        #1 rst = 1'b1;
        #2;
        check("rst_req_ready",  32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_resp_error", 32'(bus.resp_error), 32'd0);
        check("rst_mem_we",     32'(bus.mem_write_en), 32'd0);
        check("rst_mem_addr",   bus.mem_addr, 32'h0);
        check("rst_mem_wdata",  bus.mem_write_data, 32'h0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // 1: SW then LW
        txn(1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er, wen, wdat, waddr);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_rdata", rd, 32'h0);
        check("sw_err", 32'(er), 32'd0);
        check("sw_wen_cycles", 32'(wen), 32'd1);
        check("sw_wdata", wdat, 32'hDEADBEEF);
        check("sw_waddr", waddr, 32'h10);
        txn(0, 3'b010, 32'h10, 32'h0, lat, rd, er, wen, wdat, waddr);
        check("lw_lat", 32'(lat), 32'd2);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_wen_cycles", 32'(wen), 32'd0);

        // 2: sub-word loads with sign/zero extension
        txn(0, 3'b000, 32'h13, 32'h0, lat, rd, er, wen, wdat, waddr);
        check("lb_13", rd, 32'hFFFFFFDE);
        txn(0, 3'b100, 32'h13, 32'h0, lat, rd, er, wen, wdat, waddr);
        check("lbu_13", rd, 32'h000000DE);
        txn(0, 3'b001, 32'h12, 32'h0, lat, rd, er, wen, wdat, waddr);
        check("lh_12", rd, 32'hFFFFDEAD);
        txn(0, 3'b101, 32'h10, 32'h0, lat, rd, er, wen, wdat, waddr);
        check("lhu_10", rd, 32'h0000BEEF);
        check("lhu_lat", 32'(lat), 32'd2);

        // 3: read-modify-write stores; old word at 0x11 is bytes BE AD DE 00
        txn(1, 3'b000, 32'h11, 32'h12345677, lat, rd, er, wen, wdat, waddr);
        check("sb_lat", 32'(lat), 32'd3);
        check("sb_wen_cycles", 32'(wen), 32'd1);
        check("sb_wdata", wdat, 32'h00DEAD77);
        check("sb_waddr", waddr, 32'h11);
        check("sb_err", 32'(er), 32'd0);
        txn(0, 3'b010, 32'h10, 32'h0, lat, rd, er, wen, wdat, waddr);
        check("lw_after_sb", rd, 32'hDEAD77EF);
        txn(1, 3'b001, 32'h12, 32'hAAAA5555, lat, rd, er, wen, wdat, waddr);
        check("sh_lat", 32'(lat), 32'd3);
        check("sh_wdata", wdat, 32'h00005555);
        txn(0, 3'b010, 32'h10, 32'h0, lat, rd, er, wen, wdat, waddr);
        check("lw_after_sh", rd, 32'h555577EF);

        // 4: error responses
        txn(0, 3'b010, 32'h11, 32'h0, lat, rd, er, wen, wdat, waddr);
        check("lw_mis_err", 32'(er), 32'd1);
        check("lw_mis_rdata", rd, 32'h0);
        check("lw_mis_lat", 32'(lat), 32'd1);
        check("lw_mis_wen", 32'(wen), 32'd0);
        txn(1, 3'b001, 32'h13, 32'hFFFFFFFF, lat, rd, er, wen, wdat, waddr);
        check("sh_mis_err", 32'(er), 32'd1);
        check("sh_mis_lat", 32'(lat), 32'd1);
        check("sh_mis_wen", 32'(wen), 32'd0);
        txn(0, 3'b011, 32'h10, 32'h0, lat, rd, er, wen, wdat, waddr);
        check("f3_011_err", 32'(er), 32'd1);
        check("f3_011_rdata", rd, 32'h0);
        check("f3_011_lat", 32'(lat), 32'd1);
        txn(1, 3'b100, 32'h10, 32'hFFFFFFFF, lat, rd, er, wen, wdat, waddr);
        check("st_f3_100_err", 32'(er), 32'd1);
        check("st_f3_100_wen", 32'(wen), 32'd0);
        txn(0, 3'b010, 32'h10, 32'h0, lat, rd, er, wen, wdat, waddr);
        check("mem_untouched_by_errors", rd, 32'h555577EF);

        // 5: backpressure
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h10; bus.req_wdata = '0;
        @(posedge clk); #1;
        bus.req_write = 1'b1; bus.req_addr = 32'h40; bus.req_wdata = 32'h11111111;
        @(posedge clk); #1;
        check("bp_valid_up", 32'(bus.resp_valid), 32'd1);
        held = bus.resp_rdata;
        check("bp_rdata", held, 32'h555577EF);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_valid_held", 32'(bus.resp_valid), 32'd1);
            check("bp_rdata_held", bus.resp_rdata, 32'h555577EF);
            check("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
            check("bp_no_accept_addr", bus.mem_addr, 32'h10);
            check("bp_no_write", 32'(bus.mem_write_en), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_req_ready_after", 32'(bus.req_ready), 32'd1);
        check("bp_valid_after", 32'(bus.resp_valid), 32'd0);
        check("bp_mem40_untouched", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h0);

        // 6: reset during the READ phase of SB
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h20; bus.req_wdata = 32'h000000FF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("mid_in_read", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_we", 32'(bus.mem_write_en), 32'd0);
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("mid_rst_addr", bus.mem_addr, 32'h0);
        check("mid_rst_wdata", bus.mem_write_data, 32'h0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        txn(0, 3'b010, 32'h20, 32'h0, lat, rd, er, wen, wdat, waddr);
        check("post_rst_lw", rd, 32'h0);
        check("post_rst_lat", 32'(lat), 32'd2);
        check("post_rst_err", 32'(er), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
